// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline interlock and flush controller for the 5-stage in-order core.
// Produces the write-enable / flush pair for each pipeline register plus the PC
// write enable, tracks multicycle-op waits and post-exception flush windows, and
// counts the cycles in which fetch is held.
module pipe_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_reg_j_i,
  input  logic [4:0]       id_reg_k_i,
  input  logic [4:0]       id_reg_d_i,
  input  logic             id_reg_j_ren_i,
  input  logic             id_reg_k_ren_i,
  input  logic             id_reg_d_ren_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_reg_d_i,
  input  logic             ex_mc_start_i,
  input  logic             ex_mc_done_i,
  input  logic             ex_br_mispredict_i,
  input  logic             mem_busy_i,
  input  logic             wb_excp_i,
  output logic             pc_wen_o,
  output logic             ifid_wen_o,
  output logic             ifid_flush_o,
  output logic             idex_wen_o,
  output logic             idex_flush_o,
  output logic             exmem_wen_o,
  output logic             exmem_flush_o,
  output logic             memwb_wen_o,
  output logic             memwb_flush_o,
  output logic             mc_cancel_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  // Controller states; RUN is the normal flowing state.
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MC_WAIT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  // Value loaded into the flush-window counter on an exception commit.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  // Register 0 is hard-wired to zero, so it never creates a dependency.
  always_comb begin
    load_use = 1'b0;
    if (ex_valid_i && ex_is_load_i && (ex_reg_d_i != 5'd0)) begin
      load_use = (id_reg_j_ren_i && (id_reg_j_i == ex_reg_d_i)) ||
                 (id_reg_k_ren_i && (id_reg_k_i == ex_reg_d_i)) ||
                 (id_reg_d_ren_i && (id_reg_d_i == ex_reg_d_i));
    end
  end

  // Prioritised event decode: exception, memory wait, multicycle, mispredict,
  // load-use. Only the highest active event shapes the outputs and next state.
  always_comb begin
    pc_wen_o      = 1'b1;
    ifid_wen_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_wen_o    = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_wen_o   = 1'b1;
    exmem_flush_o = 1'b0;
    memwb_wen_o   = 1'b1;
    memwb_flush_o = 1'b0;
    mc_cancel_o   = 1'b0;
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;

    if (!rst_n) begin
      pc_wen_o      = 1'b0;
      ifid_wen_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_wen_o    = 1'b0;
      idex_flush_o  = 1'b1;
      exmem_wen_o   = 1'b0;
      exmem_flush_o = 1'b1;
      memwb_wen_o   = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (wb_excp_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      memwb_flush_o = 1'b1;
      mc_cancel_o   = (state_q == MC_WAIT) || ex_mc_start_i;
      state_d       = FLUSH;
      flush_cnt_d   = FLUSH_LOAD;
    end else if (state_q == FLUSH) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      flush_cnt_d  = flush_cnt_q - 3'd1;
      if (flush_cnt_q <= 3'd1) begin
        state_d = RUN;
      end
    end else if (mem_busy_i) begin
      pc_wen_o      = 1'b0;
      ifid_wen_o    = 1'b0;
      idex_wen_o    = 1'b0;
      exmem_wen_o   = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (state_q == MC_WAIT) begin
      if (ex_mc_done_i) begin
        state_d = RUN;
      end else begin
        pc_wen_o      = 1'b0;
        ifid_wen_o    = 1'b0;
        idex_wen_o    = 1'b0;
        exmem_wen_o   = 1'b0;
        memwb_flush_o = 1'b1;
      end
    end else if (ex_mc_start_i && !ex_mc_done_i) begin
      pc_wen_o      = 1'b0;
      ifid_wen_o    = 1'b0;
      idex_wen_o    = 1'b0;
      exmem_wen_o   = 1'b0;
      memwb_flush_o = 1'b1;
      state_d       = MC_WAIT;
    end else if (ex_br_mispredict_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_wen_o     = 1'b0;
      ifid_wen_o   = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  // Stall counter advances on every held-fetch cycle and sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (!pc_wen_o && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, flush-window counter and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven bench for pipe_ctrl plus hand-written
// multicycle, exception-window, saturation and async-reset sequences.
module tb_pipe_ctrl;

  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;

  // Output bit order: pc, ifid_wen, ifid_flush, idex_wen, idex_flush,
  // exmem_wen, exmem_flush, memwb_wen, memwb_flush, mc_cancel.
  localparam logic [9:0] O_DEF   = 10'b1101010100;
  localparam logic [9:0] O_STALL = 10'b0000000110;
  localparam logic [9:0] O_MISP  = 10'b1111110100;
  localparam logic [9:0] O_LDU   = 10'b0001110100;
  localparam logic [9:0] O_EXC   = 10'b1111111110;
  localparam logic [9:0] O_EXCC  = 10'b1111111111;
  localparam logic [9:0] O_RST   = 10'b0010101010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] idRegJ = '0, idRegK = '0, idRegD = '0, exRegD = '0;
  logic idRegJRen = 0, idRegKRen = 0, idRegDRen = 0;
  logic exValid = 0, exIsLoad = 0, exMcStart = 0, exMcDone = 0;
  logic exBrMisp = 0, memBusy = 0, wbExcp = 0;

  logic pcWen, ifidWen, ifidFlush, idexWen, idexFlush;
  logic exmemWen, exmemFlush, memwbWen, memwbFlush, mcCancel;
  logic [CNT_W-1:0] stallCycles;
  logic [9:0] outVec;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0] regJ, regK, regD;
    logic [2:0] ren;
    logic       exValid, exLoad;
    logic [4:0] exRegD;
    logic       mcStart, mcDone, misp, memBusy, wbExcp;
    logic [9:0] expOut;
  } vec_t;

  vec_t vecs[14];

  pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_j_i(idRegJ), .id_reg_k_i(idRegK), .id_reg_d_i(idRegD),
    .id_reg_j_ren_i(idRegJRen), .id_reg_k_ren_i(idRegKRen), .id_reg_d_ren_i(idRegDRen),
    .ex_valid_i(exValid), .ex_is_load_i(exIsLoad), .ex_reg_d_i(exRegD),
    .ex_mc_start_i(exMcStart), .ex_mc_done_i(exMcDone),
    .ex_br_mispredict_i(exBrMisp), .mem_busy_i(memBusy), .wb_excp_i(wbExcp),
    .pc_wen_o(pcWen), .ifid_wen_o(ifidWen), .ifid_flush_o(ifidFlush),
    .idex_wen_o(idexWen), .idex_flush_o(idexFlush),
    .exmem_wen_o(exmemWen), .exmem_flush_o(exmemFlush),
    .memwb_wen_o(memwbWen), .memwb_flush_o(memwbFlush),
    .mc_cancel_o(mcCancel), .stall_cycles_o(stallCycles)
  );

  assign outVec = {pcWen, ifidWen, ifidFlush, idexWen, idexFlush,
                   exmemWen, exmemFlush, memwbWen, memwbFlush, mcCancel};

  // Free-running clock; inputs change and outputs are sampled near negedges.
  always #5 clk = ~clk;

  function automatic vec_t makeVec(input logic [4:0] j, input logic [4:0] k,
                                   input logic [4:0] d, input logic [2:0] ren,
                                   input logic v, input logic ld, input logic [4:0] exd,
                                   input logic mcs, input logic mcd, input logic mp,
                                   input logic mb, input logic [9:0] expOut);
    vec_t r;
    r.regJ = j; r.regK = k; r.regD = d; r.ren = ren;
    r.exValid = v; r.exLoad = ld; r.exRegD = exd;
    r.mcStart = mcs; r.mcDone = mcd; r.misp = mp; r.memBusy = mb;
    r.wbExcp = 1'b0; r.expOut = expOut;
    return r;
  endfunction

  // Drives every DUT input from one vector record.
  task automatic applyStimulus(input vec_t v);
    idRegJ = v.regJ; idRegK = v.regK; idRegD = v.regD;
    {idRegJRen, idRegKRen, idRegDRen} = v.ren;
    exValid = v.exValid; exIsLoad = v.exLoad; exRegD = v.exRegD;
    exMcStart = v.mcStart; exMcDone = v.mcDone; exBrMisp = v.misp;
    memBusy = v.memBusy; wbExcp = v.wbExcp;
  endtask

  task automatic idleInputs();
    vec_t v;
    v = makeVec(5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 5'd0, 0, 0, 0, 0, O_DEF);
    applyStimulus(v);
  endtask

  task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic checkCount(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: stall_cycles got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int tally;

    vecs[0]  = makeVec(5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 5'd0, 0, 0, 0, 0, O_DEF);
    vecs[1]  = makeVec(5'd0, 5'd5, 5'd0, 3'b010, 1, 1, 5'd5, 0, 0, 0, 0, O_LDU);
    vecs[2]  = makeVec(5'd0, 5'd0, 5'd0, 3'b010, 1, 1, 5'd0, 0, 0, 0, 0, O_DEF);
    vecs[3]  = makeVec(5'd7, 5'd1, 5'd2, 3'b100, 1, 1, 5'd7, 0, 0, 0, 0, O_LDU);
    vecs[4]  = makeVec(5'd1, 5'd2, 5'd9, 3'b001, 1, 1, 5'd9, 0, 0, 0, 0, O_LDU);
    vecs[5]  = makeVec(5'd0, 5'd5, 5'd0, 3'b101, 1, 1, 5'd5, 0, 0, 0, 0, O_DEF);
    vecs[6]  = makeVec(5'd0, 5'd5, 5'd0, 3'b010, 0, 1, 5'd5, 0, 0, 0, 0, O_DEF);
    vecs[7]  = makeVec(5'd0, 5'd5, 5'd0, 3'b010, 1, 0, 5'd5, 0, 0, 0, 0, O_DEF);
    vecs[8]  = makeVec(5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 5'd0, 0, 0, 1, 0, O_MISP);
    vecs[9]  = makeVec(5'd0, 5'd5, 5'd0, 3'b010, 1, 1, 5'd5, 0, 0, 1, 0, O_MISP);
    vecs[10] = makeVec(5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 5'd0, 0, 0, 1, 1, O_STALL);
    vecs[11] = makeVec(5'd0, 5'd5, 5'd0, 3'b010, 1, 1, 5'd5, 0, 0, 0, 1, O_STALL);
    vecs[12] = makeVec(5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 5'd0, 1, 1, 0, 0, O_DEF);
    vecs[13] = makeVec(5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 5'd0, 1, 1, 1, 0, O_MISP);

    // Reset state
    idleInputs();
    #1;
    checkOutput("reset_outputs", outVec, O_RST);
    checkCount("reset_count", stallCycles, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors applied in RUN
    tally = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), outVec, vecs[i].expOut);
      checkCount($sformatf("vec%0d_count", i), stallCycles, CNT_W'(tally));
      if (vecs[i].expOut[9] == 1'b0) tally++;
      @(negedge clk);
    end
    idleInputs();
    #1;
    checkCount("table_total", stallCycles, CNT_W'(tally));

    // Multicycle op: three wait cycles then done
    doReset();
    exMcStart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("mc_wait%0d", i), outVec, O_STALL);
      @(negedge clk);
    end
    exMcDone = 1'b1;
    #1;
    checkOutput("mc_done", outVec, O_DEF);
    @(negedge clk);
    idleInputs();
    exBrMisp = 1'b1;
    #1;
    checkOutput("mc_back_to_run", outVec, O_MISP);
    checkCount("mc_count", stallCycles, 4'd3);
    @(negedge clk);

    // Exception during MC_WAIT, then a two-cycle flush window
    doReset();
    exMcStart = 1'b1;
    @(negedge clk);
    exMcStart = 1'b0;
    #1;
    checkOutput("mcwait_held", outVec, O_STALL);
    wbExcp = 1'b1;
    #1;
    checkOutput("excp_in_mcwait", outVec, O_EXCC);
    @(negedge clk);
    idleInputs();
    memBusy = 1'b1;
    #1;
    checkOutput("flush_win0", outVec, O_MISP);
    @(negedge clk);
    memBusy = 1'b0;
    #1;
    checkOutput("flush_win1", outVec, O_MISP);
    @(negedge clk);
    #1;
    checkOutput("flush_exit", outVec, O_DEF);

    // Exception in RUN with and without a starting multicycle op
    wbExcp = 1'b1;
    #1;
    checkOutput("excp_run", outVec, O_EXC);
    exMcStart = 1'b1;
    #1;
    checkOutput("excp_run_mcstart", outVec, O_EXCC);
    @(negedge clk);
    idleInputs();
    repeat (FLUSH_CYC) @(negedge clk);

    // Exception beats mem_busy and load-use together
    wbExcp = 1'b1; memBusy = 1'b1;
    exValid = 1'b1; exIsLoad = 1'b1; exRegD = 5'd5; idRegK = 5'd5; idRegKRen = 1'b1;
    #1;
    checkOutput("excp_priority", outVec, O_EXC);
    @(negedge clk);
    idleInputs();
    repeat (FLUSH_CYC) @(negedge clk);

    // Saturation of the stall counter
    doReset();
    memBusy = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    checkCount("sat_14", stallCycles, 4'd14);
    repeat (6) @(negedge clk);
    #1;
    checkCount("sat_hold", stallCycles, 4'hF);

    // Asynchronous reset in the middle of MC_WAIT
    memBusy = 1'b0;
    exMcStart = 1'b1;
    @(negedge clk);
    exMcStart = 1'b0;
    #1;
    checkOutput("pre_reset_mcwait", outVec, O_STALL);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out", outVec, O_RST);
    checkCount("async_reset_count", stallCycles, 4'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    exBrMisp = 1'b1;
    #1;
    checkOutput("after_reset_run", outVec, O_MISP);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
